eth_mii_rx: RTL and testbench

- MII receive MAC front end for the 100M Ethernet path; counterpart of the MII transmit MAC.
- Takes nibbles from the PHY, hunts preamble/SFD, assembles bytes LSB-nibble-first and emits a byte stream to the packet parser.
- Computes CRC-32 on the fly and reports a per-frame status (length, CRC pass, error) at end of frame. FCS bytes are passed through, not stripped.

---
 rtl/eth_mii_rx.sv | 189 ++++++++++++++++++
 tb/tb_eth_mii_rx.sv | 360 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/eth_mii_rx.sv
// MII receive MAC front end: preamble/SFD hunt, nibble-to-byte assembly,
// on-the-fly CRC-32 and a per-frame status report at end of frame.
// FCS bytes are passed through to the byte stream, not stripped.
module eth_mii_rx #(
    parameter int unsigned MIN_PRE = 4,
    parameter int unsigned MIN_LEN = 64,
    parameter int unsigned MAX_LEN = 1518
) (
    input  logic        mii_rx_clk,
    input  logic        rst,
    input  logic        mii_rx_dv,
    input  logic        mii_rx_er,
    input  logic [3:0]  mii_rx_da,
    output logic [7:0]  rx_data,
    output logic        rx_valid,
    output logic        rx_sof,
    output logic        rx_done,
    output logic [10:0] rx_len,
    output logic        rx_crc_ok,
    output logic        rx_err
);

    localparam logic [31:0] CrcPoly    = 32'hEDB88320;
    localparam logic [31:0] CrcInit    = 32'hFFFFFFFF;
    localparam logic [31:0] CrcResidue = 32'hDEBB20E3;
    localparam logic [3:0]  NibPre     = 4'h5;
    localparam logic [3:0]  NibSfd     = 4'hD;

    typedef enum logic [2:0] {StIdle, StPre, StData, StDone, StDrop} state_e;

    state_e      state_q, state_d;
    logic [3:0]  pre_cnt_q, pre_cnt_d;
    logic [31:0] crc_q, crc_d;
    logic [3:0]  lo_nib_q, lo_nib_d;
    logic        phase_q, phase_d;   // 0: expecting low nibble, 1: high nibble
    logic [10:0] byte_cnt_q, byte_cnt_d;
    logic        er_seen_q, er_seen_d;

    logic [7:0]  data_d;
    logic        valid_d, sof_d, done_d;
    logic [10:0] len_d;
    logic        crc_ok_d, err_d;

    logic        len_short, len_long;

    // Reflected CRC-32 advanced by one nibble, LSB first.
    function automatic logic [31:0] crc_nibble(input logic [31:0] crc, input logic [3:0] nib);
        logic [31:0] c;
        c = crc;
        for (int i = 0; i < 4; i++) begin
            if (c[0] ^ nib[i]) begin
                c = (c >> 1) ^ CrcPoly;
            end else begin
                c = c >> 1;
            end
        end
        return c;
    endfunction

    assign len_short = {21'd0, byte_cnt_q} < MIN_LEN;
    assign len_long  = {21'd0, byte_cnt_q} > MAX_LEN;

    // State register.
    always_ff @(posedge mii_rx_clk) begin
        if (rst) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Datapath registers and registered outputs.
    always_ff @(posedge mii_rx_clk) begin
        if (rst) begin
            pre_cnt_q  <= '0;
            crc_q      <= CrcInit;
            lo_nib_q   <= '0;
            phase_q    <= 1'b0;
            byte_cnt_q <= '0;
            er_seen_q  <= 1'b0;
            rx_data    <= '0;
            rx_valid   <= 1'b0;
            rx_sof     <= 1'b0;
            rx_done    <= 1'b0;
            rx_len     <= '0;
            rx_crc_ok  <= 1'b0;
            rx_err     <= 1'b0;
        end else begin
            pre_cnt_q  <= pre_cnt_d;
            crc_q      <= crc_d;
            lo_nib_q   <= lo_nib_d;
            phase_q    <= phase_d;
            byte_cnt_q <= byte_cnt_d;
            er_seen_q  <= er_seen_d;
            rx_data    <= data_d;
            rx_valid   <= valid_d;
            rx_sof     <= sof_d;
            rx_done    <= done_d;
            rx_len     <= len_d;
            rx_crc_ok  <= crc_ok_d;
            rx_err     <= err_d;
        end
    end

    // Next-state, datapath updates and output strobes.
    always_comb begin
        state_d    = state_q;
        pre_cnt_d  = pre_cnt_q;
        crc_d      = crc_q;
        lo_nib_d   = lo_nib_q;
        phase_d    = phase_q;
        byte_cnt_d = byte_cnt_q;
        er_seen_d  = er_seen_q;
        data_d     = rx_data;
        valid_d    = 1'b0;
        sof_d      = 1'b0;
        done_d     = 1'b0;
        len_d      = rx_len;
        crc_ok_d   = rx_crc_ok;
        err_d      = rx_err;

        unique case (state_q)
            // DONE samples the line exactly like IDLE so a frame may follow
            // after a single dv=0 cycle without losing a preamble nibble.
            StIdle, StDone: begin
                state_d = StIdle;
                if (mii_rx_dv) begin
                    if (mii_rx_da == NibPre) begin
                        state_d   = StPre;
                        pre_cnt_d = 4'd1;
                        er_seen_d = mii_rx_er;
                    end else begin
                        state_d = StDrop;
                    end
                end
            end
            StPre: begin
                if (!mii_rx_dv) begin
                    state_d = StIdle;
                end else begin
                    er_seen_d = er_seen_q | mii_rx_er;
                    if (mii_rx_da == NibPre) begin
                        if (pre_cnt_q != 4'hF) begin
                            pre_cnt_d = pre_cnt_q + 4'd1;
                        end
                    end else if (mii_rx_da == NibSfd && {28'd0, pre_cnt_q} >= MIN_PRE) begin
                        state_d    = StData;
                        crc_d      = CrcInit;
                        phase_d    = 1'b0;
                        byte_cnt_d = '0;
                    end else begin
                        state_d = StDrop;
                    end
                end
            end
            StData: begin
                if (!mii_rx_dv) begin
                    state_d  = StDone;
                    done_d   = 1'b1;
                    len_d    = byte_cnt_q;
                    // A dangling nibble is dropped and invalidates the CRC.
                    crc_ok_d = !phase_q && (crc_q == CrcResidue);
                    err_d    = er_seen_q | phase_q | len_short | len_long;
                end else begin
                    er_seen_d = er_seen_q | mii_rx_er;
                    crc_d     = crc_nibble(crc_q, mii_rx_da);
                    phase_d   = ~phase_q;
                    if (!phase_q) begin
                        lo_nib_d = mii_rx_da;
                    end else begin
                        data_d  = {mii_rx_da, lo_nib_q};
                        valid_d = 1'b1;
                        sof_d   = (byte_cnt_q == 11'd0);
                        if (byte_cnt_q != 11'h7FF) begin
                            byte_cnt_d = byte_cnt_q + 11'd1;
                        end
                    end
                end
            end
            StDrop: begin
                if (!mii_rx_dv) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

endmodule

// File: tb/tb_eth_mii_rx.sv
// Directed bench for eth_mii_rx: ARP broadcast frame with computed FCS,
// corrupted / errored / runt / odd frames, bad preambles, back-to-back
// frames and a mid-frame reset.
module tb_eth_mii_rx;

    logic        clk;
    logic        rst;
    logic        dv;
    logic        er;
    logic [3:0]  da;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        rx_sof;
    logic        rx_done;
    logic [10:0] rx_len;
    logic        rx_crc_ok;
    logic        rx_err;

    int tests_run    = 0;
    int tests_failed = 0;

    // Monitor state (written only by the monitor process).
    int         mon_cyc        = 0;
    int         mon_valid      = 0;
    int         mon_sof        = 0;
    int         mon_done       = 0;
    int         mon_ok         = 0;
    int         last_valid_cyc = 0;
    int         done_cyc       = 0;
    logic [7:0] sof_byte       = 8'h00;
    logic [7:0] got[$];

    // Snapshot of outputs taken right after a mid-frame reset edge.
    logic [23:0] snap = '1;

    logic [7:0] good[$];
    logic [7:0] tx[$];

    eth_mii_rx dut (
        .mii_rx_clk (clk),
        .rst        (rst),
        .mii_rx_dv  (dv),
        .mii_rx_er  (er),
        .mii_rx_da  (da),
        .rx_data    (rx_data),
        .rx_valid   (rx_valid),
        .rx_sof     (rx_sof),
        .rx_done    (rx_done),
        .rx_len     (rx_len),
        .rx_crc_ok  (rx_crc_ok),
        .rx_err     (rx_err)
    );

    initial clk = 1'b0;
    always #20 clk = ~clk;

    // Monitor: sample outputs 1 ns after each rising edge.
    always @(posedge clk) begin
        #1;
        mon_cyc++;
        if (rx_valid) begin
            got.push_back(rx_data);
            mon_valid++;
            last_valid_cyc = mon_cyc;
            if (rx_sof) begin
                mon_sof++;
                sof_byte = rx_data;
            end
        end
        if (rx_done) begin
            mon_done++;
            done_cyc = mon_cyc;
            if (rx_crc_ok) mon_ok++;
        end
    end

    task automatic drive(input logic v, input logic e, input logic [3:0] d, input logic r);
        @(negedge clk);
        dv  = v;
        er  = e;
        da  = d;
        rst = r;
    endtask

    task automatic idle(input int n);
        repeat (n) drive(1'b0, 1'b0, 4'h0, 1'b0);
    endtask

    // Bytewise reference CRC-32; returns the FCS value (complemented).
    function automatic logic [31:0] fcs_of(input int n);
        logic [31:0] c;
        c = 32'hFFFFFFFF;
        for (int i = 0; i < n; i++) begin
            c = c ^ {24'd0, good[i]};
            for (int b = 0; b < 8; b++) begin
                c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
            end
        end
        return ~c;
    endfunction

    task automatic build_arp();
        logic [7:0] hdr[42];
        logic [31:0] f;
        hdr = '{8'hff, 8'hff, 8'hff, 8'hff, 8'hff, 8'hff,
                8'h00, 8'h0a, 8'h35, 8'h01, 8'hfe, 8'hc0,
                8'h08, 8'h06,
                8'h00, 8'h01, 8'h08, 8'h00, 8'h06, 8'h04, 8'h00, 8'h01,
                8'h00, 8'h0a, 8'h35, 8'h01, 8'hfe, 8'hc0,
                8'hc0, 8'ha8, 8'h01, 8'h0a,
                8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00,
                8'hc0, 8'ha8, 8'h01, 8'h01};
        good.delete();
        for (int i = 0; i < 42; i++) good.push_back(hdr[i]);
        while (good.size() < 60) good.push_back(8'h00);
        f = fcs_of(60);
        good.push_back(f[7:0]);
        good.push_back(f[15:8]);
        good.push_back(f[23:16]);
        good.push_back(f[31:24]);
    endtask

    // Sends npre preamble nibbles, SFD, then tx[] LSB nibble first.
    // flip/er/rst indices refer to data nibbles (-1 = none).
    task automatic send_frame(input int npre, input int flip_nib, input int er_nib,
                              input int rst_nib, input bit extra);
        logic [3:0] nib;
        for (int i = 0; i < npre; i++) drive(1'b1, 1'b0, 4'h5, 1'b0);
        drive(1'b1, 1'b0, 4'hD, 1'b0);
        for (int k = 0; k < 2 * tx.size(); k++) begin
            nib = k[0] ? tx[k / 2][7:4] : tx[k / 2][3:0];
            if (k == flip_nib) nib = nib ^ 4'h8;
            drive(1'b1, k == er_nib, nib, k == rst_nib);
            if (k == rst_nib) begin
                @(posedge clk);
                #1;
                snap = {rx_data, rx_valid, rx_sof, rx_done, rx_len, rx_crc_ok, rx_err};
            end
        end
        if (extra) drive(1'b1, 1'b0, 4'hA, 1'b0);
    endtask

    task automatic test_reset();
        drive(1'b0, 1'b0, 4'h0, 1'b1);
        drive(1'b0, 1'b0, 4'h0, 1'b1);
        drive(1'b0, 1'b0, 4'h0, 1'b0);
        tests_run++;
        if (rx_data !== 8'h00) begin
            tests_failed++; $display("FAIL reset_data: got %h want 00", rx_data);
        end
        tests_run++;
        if ({rx_valid, rx_sof, rx_done} !== 3'b000) begin
            tests_failed++; $display("FAIL reset_strobes: got %b want 000", {rx_valid, rx_sof, rx_done});
        end
        tests_run++;
        if (rx_len !== 11'd0) begin
            tests_failed++; $display("FAIL reset_len: got %0d want 0", rx_len);
        end
        tests_run++;
        if ({rx_crc_ok, rx_err} !== 2'b00) begin
            tests_failed++; $display("FAIL reset_status: got %b want 00", {rx_crc_ok, rx_err});
        end
    endtask

    task automatic test_good_frame();
        int v0, d0, s0, base, bad;
        v0 = mon_valid; d0 = mon_done; s0 = mon_sof; base = got.size();
        tx = good;
        send_frame(15, -1, -1, -1, 1'b0);
        idle(4);
        tests_run++;
        if (mon_valid - v0 !== 64) begin
            tests_failed++; $display("FAIL good_count: got %0d want 64", mon_valid - v0);
        end
        bad = 0;
        for (int i = 0; i < 64; i++) if (got.size() <= base + i || got[base + i] !== good[i]) bad++;
        tests_run++;
        if (bad !== 0) begin
            tests_failed++; $display("FAIL good_bytes: got %0d mismatched want 0", bad);
        end
        tests_run++;
        if (mon_sof - s0 !== 1 || sof_byte !== 8'hFF) begin
            tests_failed++;
            $display("FAIL good_sof: got %0d sof byte %h want 1 sof byte ff", mon_sof - s0, sof_byte);
        end
        tests_run++;
        if (mon_done - d0 !== 1) begin
            tests_failed++; $display("FAIL good_done: got %0d want 1", mon_done - d0);
        end
        tests_run++;
        if (done_cyc - last_valid_cyc !== 1) begin
            tests_failed++; $display("FAIL good_done_lat: got %0d want 1", done_cyc - last_valid_cyc);
        end
        tests_run++;
        if ({rx_len, rx_crc_ok, rx_err} !== {11'd64, 1'b1, 1'b0}) begin
            tests_failed++;
            $display("FAIL good_status: got len %0d ok %b err %b want 64 1 0", rx_len, rx_crc_ok, rx_err);
        end
    endtask

    task automatic test_crc_error();
        int v0;
        v0 = mon_valid;
        tx = good;
        send_frame(15, 60, -1, -1, 1'b0);
        idle(4);
        tests_run++;
        if (mon_valid - v0 !== 64) begin
            tests_failed++; $display("FAIL crc_count: got %0d want 64", mon_valid - v0);
        end
        tests_run++;
        if ({rx_len, rx_crc_ok, rx_err} !== {11'd64, 1'b0, 1'b0}) begin
            tests_failed++;
            $display("FAIL crc_status: got len %0d ok %b err %b want 64 0 0", rx_len, rx_crc_ok, rx_err);
        end
    endtask

    task automatic test_rx_er();
        tx = good;
        send_frame(15, -1, 40, -1, 1'b0);
        idle(4);
        tests_run++;
        if ({rx_len, rx_err} !== {11'd64, 1'b1}) begin
            tests_failed++; $display("FAIL er_status: got len %0d err %b want 64 1", rx_len, rx_err);
        end
    endtask

    task automatic test_runt();
        int v0;
        v0 = mon_valid;
        tx.delete();
        tx.push_back(8'h01); tx.push_back(8'h02); tx.push_back(8'h03);
        send_frame(7, -1, -1, -1, 1'b0);
        idle(4);
        tests_run++;
        if (mon_valid - v0 !== 3) begin
            tests_failed++; $display("FAIL runt_count: got %0d want 3", mon_valid - v0);
        end
        tests_run++;
        if ({rx_len, rx_crc_ok, rx_err} !== {11'd3, 1'b0, 1'b1}) begin
            tests_failed++;
            $display("FAIL runt_status: got len %0d ok %b err %b want 3 0 1", rx_len, rx_crc_ok, rx_err);
        end
    endtask

    task automatic test_bad_preamble();
        int v0, d0;
        logic [3:0] p1[13];
        logic [3:0] p2[13];
        p1 = '{4'h5, 4'h5, 4'h7, 4'h5, 4'h5, 4'h5, 4'h5, 4'hD, 4'hF, 4'hF, 4'hF, 4'hF, 4'h1};
        p2 = '{4'h5, 4'h5, 4'hD, 4'hF, 4'hF, 4'hF, 4'hF, 4'h0, 4'h1, 4'h2, 4'h3, 4'h4, 4'h5};
        v0 = mon_valid; d0 = mon_done;
        for (int i = 0; i < 13; i++) drive(1'b1, 1'b0, p1[i], 1'b0);
        idle(2);
        for (int i = 0; i < 13; i++) drive(1'b1, 1'b0, p2[i], 1'b0);
        idle(3);
        tests_run++;
        if (mon_valid - v0 !== 0) begin
            tests_failed++; $display("FAIL badpre_valid: got %0d want 0", mon_valid - v0);
        end
        tests_run++;
        if (mon_done - d0 !== 0) begin
            tests_failed++; $display("FAIL badpre_done: got %0d want 0", mon_done - d0);
        end
        v0 = mon_valid;
        tx = good;
        send_frame(15, -1, -1, -1, 1'b0);
        idle(4);
        tests_run++;
        if (mon_valid - v0 !== 64 || {rx_len, rx_crc_ok, rx_err} !== {11'd64, 1'b1, 1'b0}) begin
            tests_failed++;
            $display("FAIL badpre_next: got %0d bytes len %0d ok %b err %b want 64 64 1 0",
                     mon_valid - v0, rx_len, rx_crc_ok, rx_err);
        end
    endtask

    task automatic test_odd_nibble();
        int v0;
        v0 = mon_valid;
        tx = good;
        send_frame(15, -1, -1, -1, 1'b1);
        idle(4);
        tests_run++;
        if (mon_valid - v0 !== 64) begin
            tests_failed++; $display("FAIL odd_count: got %0d want 64", mon_valid - v0);
        end
        tests_run++;
        if ({rx_len, rx_crc_ok, rx_err} !== {11'd64, 1'b0, 1'b1}) begin
            tests_failed++;
            $display("FAIL odd_status: got len %0d ok %b err %b want 64 0 1", rx_len, rx_crc_ok, rx_err);
        end
    endtask

    task automatic test_back_to_back();
        int v0, d0, k0;
        v0 = mon_valid; d0 = mon_done; k0 = mon_ok;
        tx = good;
        send_frame(15, -1, -1, -1, 1'b0);
        idle(1);
        send_frame(8, -1, -1, -1, 1'b0);
        idle(4);
        tests_run++;
        if (mon_valid - v0 !== 128) begin
            tests_failed++; $display("FAIL b2b_count: got %0d want 128", mon_valid - v0);
        end
        tests_run++;
        if (mon_done - d0 !== 2) begin
            tests_failed++; $display("FAIL b2b_done: got %0d want 2", mon_done - d0);
        end
        tests_run++;
        if (mon_ok - k0 !== 2) begin
            tests_failed++; $display("FAIL b2b_crc_ok: got %0d want 2", mon_ok - k0);
        end
    endtask

    task automatic test_reset_mid_frame();
        int d0, v0;
        d0 = mon_done;
        tx = good;
        send_frame(15, -1, -1, 60, 1'b0);
        idle(4);
        tests_run++;
        if (snap !== 24'd0) begin
            tests_failed++; $display("FAIL rstmid_outputs: got %h want 000000", snap);
        end
        tests_run++;
        if (mon_done - d0 !== 0) begin
            tests_failed++; $display("FAIL rstmid_done: got %0d want 0", mon_done - d0);
        end
        v0 = mon_valid;
        send_frame(15, -1, -1, -1, 1'b0);
        idle(4);
        tests_run++;
        if (mon_valid - v0 !== 64 || {rx_len, rx_crc_ok, rx_err} !== {11'd64, 1'b1, 1'b0}) begin
            tests_failed++;
            $display("FAIL rstmid_next: got %0d bytes len %0d ok %b err %b want 64 64 1 0",
                     mon_valid - v0, rx_len, rx_crc_ok, rx_err);
        end
    endtask

    initial begin
        rst = 1'b1;
        dv  = 1'b0;
        er  = 1'b0;
        da  = 4'h0;
        build_arp();
        test_reset();
        test_good_frame();
        test_crc_error();
        test_rx_er();
        test_runt();
        test_bad_preamble();
        test_odd_nibble();
        test_back_to_back();
        test_reset_mid_frame();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
